// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle data memory between the I-cache
// refill port (0) and the D-cache port (1); reads are block refills, writes single-word.
module dmem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int OFFS_W  = 2,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ready0,
  output logic              ready1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [OFFS_W-1:0] rword0,
  output logic [OFFS_W-1:0] rword1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                last_gnt_q, last_gnt_d;
  logic [OFFS_W-1:0]   word_cnt_q, word_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [OFFS_W-1:0]   rword0_q, rword0_d;
  logic [OFFS_W-1:0]   rword1_q, rword1_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                sel_we;

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    last_gnt_d = last_gnt_q;
    word_cnt_d = word_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rword0_d   = rword0_q;
    rword1_d   = rword1_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not served last wins
          port_d     = req1 & (~req0 | ~last_gnt_q);
          sel_we     = port_d ? we1 : we0;
          addr_d     = port_d ? addr1 : addr0;
          wdata_d    = port_d ? wdata1 : wdata0;
          word_cnt_d = '0;
          lat_cnt_d  = '0;
          state_d    = sel_we ? WR : RD;
        end
      end
      RD: begin
        if (lat_cnt_q == LAT_LAST) begin
          if (port_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = mem_rdata;
            rword1_d  = word_cnt_q;
          end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = mem_rdata;
            rword0_d  = word_cnt_q;
          end
          word_cnt_d = word_cnt_q + 1'b1;
          lat_cnt_d  = '0;
          if (word_cnt_q == '1) state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      WR: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d = '0;
          state_d   = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      DONE: begin
        last_gnt_d = port_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      last_gnt_q <= 1'b1;
      word_cnt_q <= '0;
      lat_cnt_q  <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rword0_q   <= '0;
      rword1_q   <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      last_gnt_q <= last_gnt_d;
      word_cnt_q <= word_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rword0_q   <= rword0_d;
      rword1_q   <= rword1_d;
    end
  end

  // Latched request payload is only consumed while the FSM is busy
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign gnt0      = (state_q != IDLE) && !port_q;
  assign gnt1      = (state_q != IDLE) && port_q;
  assign ready0    = (state_q == DONE) && !port_q;
  assign ready1    = (state_q == DONE) && port_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = gnt0 ? rdata0_q : '0;
  assign rdata1    = gnt1 ? rdata1_q : '0;
  assign rword0    = gnt0 ? rword0_q : '0;
  assign rword1    = gnt1 ? rword1_q : '0;
  assign mem_en    = (state_q == RD) || (state_q == WR);
  assign mem_we    = (state_q == WR);
  assign mem_addr  = (state_q == RD) ? {addr_q[ADDR_W-1:OFFS_W], word_cnt_q} :
                     (state_q == WR) ? addr_q : '0;
  assign mem_wdata = (state_q == WR) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int OW  = 2;
  localparam int LAT = 2;
  localparam int NW  = 1 << OW;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    gnt, ready, rvalid;
  logic [DW-1:0] rdata0, rdata1;
  logic [OW-1:0] rword0, rword1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          b_req, b_gnt, b_ready, b_rvalid, b_mem_en, b_mem_we;
  logic          b_gnt1, b_ready1, b_rvalid1;
  logic [DW-1:0] b_rdata, b_rdata1, b_mem_wdata, b_mem_rdata;
  logic [OW-1:0] b_rword, b_rword1;
  logic [AW-1:0] b_addr, b_mem_addr;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  assign mem_rdata   = memf(mem_addr);
  assign b_mem_rdata = memf(b_mem_addr);

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .OFFS_W(OW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .ready0(ready[0]), .ready1(ready[1]),
    .rvalid0(rvalid[0]), .rvalid1(rvalid[1]),
    .rdata0(rdata0), .rdata1(rdata1), .rword0(rword0), .rword1(rword1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .OFFS_W(OW), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req0(b_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(b_addr), .addr1('0), .wdata0('0), .wdata1('0),
    .gnt0(b_gnt), .gnt1(b_gnt1), .ready0(b_ready), .ready1(b_ready1),
    .rvalid0(b_rvalid), .rvalid1(b_rvalid1),
    .rdata0(b_rdata), .rdata1(b_rdata1), .rword0(b_rword), .rword1(b_rword1),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    req   = '0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_ready;
    int            exp_nrv;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vt [5];

  // table-run bookkeeping
  int            p, ready_c, nrv, got;
  logic          seen_en, mwe, bad_rv, other;
  logic [AW-1:0] first_a, last_a;
  logic [DW-1:0] wd, rd;
  logic [OW-1:0] rw;

  // reference model state
  logic          m_busy, m_we;
  int            m_port, m_k, m_last, tt, w, j;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] h_data [2];
  logic [OW-1:0] h_word [2];
  logic [1:0]    e_gnt, e_ready, e_rvalid;
  logic          e_en, e_we;
  logic [AW-1:0] e_maddr;
  logic [DW-1:0] e_mwd;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 10'h0A5, 32'h0,        9, 4, 10'h0A4, 10'h0A7};
    vt[1] = '{1'b0, 1'b1, 10'h3FF, 32'hDEADBEEF, 3, 0, 10'h3FF, 10'h3FF};
    vt[2] = '{1'b0, 1'b0, 10'h000, 32'h0,        9, 4, 10'h000, 10'h003};
    vt[3] = '{1'b1, 1'b1, 10'h123, 32'h12345678, 3, 0, 10'h123, 10'h123};
    vt[4] = '{1'b1, 1'b0, 10'h3FE, 32'h0,        9, 4, 10'h3FC, 10'h3FF};

    rst = 1'b0; req = '0; we = '0; b_req = 1'b0; b_addr = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdata", 64'(rdata0 | rdata1), 64'(0));
    rst = 1'b1;

    // Vector table: isolated transactions
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      p = int'(vt[i].port);
      req[p] = 1'b1; we[p] = vt[i].we; addr[p] = vt[i].addr; wdata[p] = vt[i].wdata;
      ready_c = 0; nrv = 0; seen_en = 0; mwe = 0; bad_rv = 0; other = 0;
      first_a = '0; last_a = '0; wd = '0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        rd = p ? rdata1 : rdata0;
        rw = p ? rword1 : rword0;
        if (mem_en) begin
          if (!seen_en) begin first_a = mem_addr; mwe = mem_we; wd = mem_wdata; seen_en = 1; end
          last_a = mem_addr;
        end
        if (rvalid[p]) begin
          if (rw != nrv[OW-1:0] || rd != memf({vt[i].addr[AW-1:OW], nrv[OW-1:0]})) bad_rv = 1;
          nrv++;
        end
        if (gnt[1-p] || ready[1-p] || rvalid[1-p]) other = 1;
        if (ready[p] && ready_c == 0) begin ready_c = c; req[p] = 1'b0; end
      end
      req[p] = 1'b0;
      chk($sformatf("vec%0d_ready_cycle", i), 64'(ready_c), 64'(vt[i].exp_ready));
      chk($sformatf("vec%0d_rvalid_count", i), 64'(nrv), 64'(vt[i].exp_nrv));
      chk($sformatf("vec%0d_first_addr", i), 64'(first_a), 64'(vt[i].exp_first));
      chk($sformatf("vec%0d_last_addr", i), 64'(last_a), 64'(vt[i].exp_last));
      chk($sformatf("vec%0d_mem_we", i), 64'(mwe), 64'(vt[i].we));
      chk($sformatf("vec%0d_rword_rdata", i), 64'(bad_rv), 64'(0));
      chk($sformatf("vec%0d_other_port_quiet", i), 64'(other), 64'(0));
      if (vt[i].we) chk($sformatf("vec%0d_mem_wdata", i), 64'(wd), 64'(vt[i].wdata));
    end

    // Exact cycle timing of a port-1 refill
    do_reset();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h0A5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("t1_gnt1", 64'(gnt[1]), 64'(c <= 9));
      chk("t1_rvalid1", 64'(rvalid[1]), 64'(c == 3 || c == 5 || c == 7 || c == 9));
      chk("t1_ready1", 64'(ready[1]), 64'(c == 9));
      if (c <= 8) chk("t1_mem_addr", 64'(mem_addr), 64'(10'h0A4 + (c - 1) / 2));
      if (rvalid[1]) chk("t1_rword1", 64'(rword1), 64'((c - 3) / 2));
      if (c == 9) req[1] = 1'b0;
    end

    // Tie after reset, waiting requester, alternation
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 10'h100; addr[1] = 10'h200;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      chk("tie_gnt0", 64'(gnt[0]), 64'(c <= 9 || c == 21));
      chk("tie_gnt1", 64'(gnt[1]), 64'(c >= 11 && c <= 19));
      if (c == 9 || c == 10) chk("tie_mem_en_gap", 64'(mem_en), 64'(0));
      if (c == 8) chk("tie_last_addr0", 64'(mem_addr), 64'(10'h103));
      if (c == 11) chk("tie_first_addr1", 64'(mem_addr), 64'(10'h200));
      if (c == 9) begin chk("tie_ready0", 64'(ready[0]), 64'(1)); req[0] = 1'b0; end
      if (c == 19) begin chk("tie_ready1", 64'(ready[1]), 64'(1)); req[1] = 1'b0; end
      if (c == 20) req = 2'b11;
    end

    // Reset in the middle of a read, then re-serve the held request
    do_reset();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 10'h0A5;
    repeat (4) @(negedge clk);
    chk("rst5_pre_gnt1", 64'(gnt[1]), 64'(1));
    chk("rst5_pre_rdata1", 64'(rdata1), 64'(memf(10'h0A4)));
    rst = 1'b0;
    #1;
    chk("rst5_gnt", 64'(gnt), 64'(0));
    chk("rst5_mem_en", 64'(mem_en), 64'(0));
    chk("rst5_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst5_rvalid", 64'(rvalid), 64'(0));
    chk("rst5_rdata1", 64'(rdata1), 64'(0));
    chk("rst5_rword1", 64'(rword1), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst5_re_gnt1", 64'(gnt[1]), 64'(1));
    chk("rst5_re_addr_c1", 64'(mem_addr), 64'(10'h0A4));
    @(negedge clk);
    chk("rst5_re_addr_c2", 64'(mem_addr), 64'(10'h0A4));
    @(negedge clk);
    chk("rst5_re_rvalid", 64'(rvalid[1]), 64'(1));
    chk("rst5_re_rword", 64'(rword1), 64'(0));
    chk("rst5_re_rdata", 64'(rdata1), 64'(memf(10'h0A4)));
    got = 0;
    for (int c = 4; c <= 12; c++) begin
      @(negedge clk);
      if (ready[1] && got == 0) begin got = c; req[1] = 1'b0; end
    end
    req[1] = 1'b0;
    chk("rst5_re_ready_cycle", 64'(got), 64'(9));

    // Single-cycle memory latency instance
    do_reset();
    b_req = 1'b1; b_addr = 10'h010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("l1_rvalid0", 64'(b_rvalid), 64'(c >= 2 && c <= 5));
      chk("l1_ready0", 64'(b_ready), 64'(c == 5));
      if (c <= 4) chk("l1_mem_addr", 64'(b_mem_addr), 64'(10'h010 + c - 1));
      if (b_rvalid) begin
        chk("l1_rword0", 64'(b_rword), 64'(c - 2));
        chk("l1_rdata0", 64'(b_rdata), 64'(memf(AW'(10'h010 + c - 2))));
      end
      if (c == 5) b_req = 1'b0;
    end

    // Randomized traffic against the transaction-level model
    do_reset();
    m_busy = 0; m_we = 0; m_port = 0; m_k = 0; m_last = 1; m_addr = '0; m_wdata = '0;
    h_data[0] = '0; h_data[1] = '0; h_word[0] = '0; h_word[1] = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      tt = m_we ? LAT + 1 : NW * LAT + 1;
      e_gnt = '0; e_ready = '0; e_rvalid = '0; e_en = 0; e_we = 0; e_maddr = '0; e_mwd = '0;
      if (m_busy) begin
        e_gnt[m_port] = 1'b1;
        if (m_k < tt) begin
          e_en = 1; e_we = m_we; e_mwd = m_wdata;
          e_maddr = m_we ? m_addr : {m_addr[AW-1:OW], OW'((m_k - 1) / LAT)};
        end else begin
          e_ready[m_port] = 1'b1;
        end
        if (!m_we && m_k > 1 && (m_k - 1) % LAT == 0) begin
          j = (m_k - 1) / LAT - 1;
          e_rvalid[m_port] = 1'b1;
          h_word[m_port] = OW'(j);
          h_data[m_port] = memf({m_addr[AW-1:OW], OW'(j)});
        end
      end
      chk("rnd_gnt", 64'(gnt), 64'(e_gnt));
      chk("rnd_ready", 64'(ready), 64'(e_ready));
      chk("rnd_rvalid", 64'(rvalid), 64'(e_rvalid));
      chk("rnd_mem_en", 64'(mem_en), 64'(e_en));
      chk("rnd_mem_we", 64'(mem_we), 64'(e_we));
      if (e_en) chk("rnd_mem_addr", 64'(mem_addr), 64'(e_maddr));
      if (e_we) chk("rnd_mem_wdata", 64'(mem_wdata), 64'(e_mwd));
      chk("rnd_rdata0", 64'(rdata0), 64'(e_gnt[0] ? h_data[0] : '0));
      chk("rnd_rdata1", 64'(rdata1), 64'(e_gnt[1] ? h_data[1] : '0));
      chk("rnd_rword0", 64'(rword0), 64'(e_gnt[0] ? h_word[0] : '0));
      chk("rnd_rword1", 64'(rword1), 64'(e_gnt[1] ? h_word[1] : '0));

      for (int q = 0; q < 2; q++) begin
        if (e_ready[q]) begin
          req[q] = 1'b0;
        end else if (!req[q]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[q] = 1'b1;
            we[q] = ($urandom_range(0, 2) == 0);
            addr[q] = AW'($urandom);
            wdata[q] = $urandom;
          end
        end else if (m_busy && m_port == q && $urandom_range(0, 1) == 1) begin
          we[q] = ~we[q];
          addr[q] = AW'($urandom);
          wdata[q] = $urandom;
        end
      end

      if (!m_busy) begin
        if (req[0] || req[1]) begin
          w = (req[0] && req[1]) ? 1 - m_last : (req[1] ? 1 : 0);
          m_busy = 1; m_port = w; m_we = we[w]; m_addr = addr[w]; m_wdata = wdata[w]; m_k = 1;
        end
      end else if (m_k == tt) begin
        m_busy = 0;
        m_last = m_port;
      end else begin
        m_k++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
